// File: rtl/dependency_check_block.sv
// rtl/dependency_check_block.sv - operand-fetch hazard unit: forwarding selects and load-use stall for RB_Block
// Tracks in-flight destinations through EX/DM/WB and drives RB_Block's operand controls.
module dependency_check_block #(
  parameter int          DATA_W     = 16,
  parameter int          REG_AW     = 5,
  parameter logic [5:0]  NOP_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic              ins_valid,
  output logic              stall,
  output logic [REG_AW-1:0] RA,
  output logic [REG_AW-1:0] RB,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic              imm_sel,
  output logic [REG_AW-1:0] RW_dm,
  output logic              wr_dm
);

  localparam logic [1:0] CLS_RR    = 2'b00;
  localparam logic [1:0] CLS_RI    = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_DM  = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rw;
    logic              wr;
    logic              is_load;
  } stage_t;

  stage_t            of_st;
  stage_t            ex_st;
  stage_t            dm_st;
  stage_t            wb_st;
  logic [REG_AW-1:0] of_ra;
  logic [REG_AW-1:0] of_rb;
  logic [DATA_W-1:0] of_imm;
  logic [1:0]        of_cls;
  logic              of_nop;

  logic [5:0]        dec_op;
  logic [1:0]        dec_cls;
  logic              dec_nop;
  logic              dec_wr;
  stage_t            dec_st;

  logic              of_rd_a;
  logic              of_rd_b;
  logic              hz_a;
  logic              hz_b;

  always_comb begin
    dec_op  = ins[31:26];
    dec_cls = dec_op[5:4];
    dec_nop = (dec_op == NOP_OPCODE);
    dec_wr  = !dec_nop && (dec_cls != CLS_STORE);
    dec_st.valid   = 1'b1;
    dec_st.wr      = dec_wr;
    // Non-writers carry RW=0 so a bubble or store never shows up on RW_dm.
    dec_st.rw      = dec_wr ? REG_AW'(ins[25:21]) : '0;
    dec_st.is_load = !dec_nop && (dec_cls == CLS_LOAD);
  end

  always_comb begin
    of_rd_a = of_st.valid && !of_nop;
    of_rd_b = of_st.valid && !of_nop && ((of_cls == CLS_RR) || (of_cls == CLS_STORE));
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              rd,
    input stage_t            ex,
    input stage_t            dm,
    input stage_t            wb
  );
    logic [1:0] sel;
    sel = SEL_REG;
    if (rd && (src != '0)) begin
      // A load in EX has no result yet; the stall covers that case.
      if (ex.valid && ex.wr && (ex.rw == src) && !ex.is_load)
        sel = SEL_EX;
      else if (dm.valid && dm.wr && (dm.rw == src))
        sel = SEL_DM;
      else if (wb.valid && wb.wr && (wb.rw == src))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    hz_a      = of_rd_a && (of_ra == ex_st.rw);
    hz_b      = of_rd_b && (of_rb == ex_st.rw);
    stall     = ex_st.valid && ex_st.is_load && (ex_st.rw != '0) && (hz_a || hz_b);
    mux_sel_A = fwd_sel(of_ra, of_rd_a, ex_st, dm_st, wb_st);
    mux_sel_B = fwd_sel(of_rb, of_rd_b, ex_st, dm_st, wb_st);
    imm_sel   = of_st.valid && !of_nop && ((of_cls == CLS_RI) || (of_cls == CLS_LOAD));
    RA        = of_ra;
    RB        = of_rb;
    imm       = of_imm;
    RW_dm     = dm_st.rw;
    wr_dm     = dm_st.valid && dm_st.wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_st  <= '0;
      ex_st  <= '0;
      dm_st  <= '0;
      wb_st  <= '0;
      of_ra  <= '0;
      of_rb  <= '0;
      of_imm <= '0;
      of_cls <= CLS_RR;
      of_nop <= 1'b0;
    end else begin
      if (stall) begin
        ex_st <= '0;
      end else begin
        ex_st <= of_st;
        if (ins_valid) begin
          of_st  <= dec_st;
          of_ra  <= REG_AW'(ins[20:16]);
          of_rb  <= REG_AW'(ins[15:11]);
          of_imm <= DATA_W'(ins[15:0]);
          of_cls <= dec_cls;
          of_nop <= dec_nop;
        end else begin
          of_st  <= '0;
          of_ra  <= '0;
          of_rb  <= '0;
          of_imm <= '0;
          of_cls <= CLS_RR;
          of_nop <= 1'b0;
        end
      end
      dm_st <= ex_st;
      wb_st <= dm_st;
    end
  end

endmodule

// File: tb/tb_dependency_check_block.sv
// tb/tb_dependency_check_block.sv - directed self-checking bench for dependency_check_block
// Hand-computed expectations for forwarding, load-use stall, reset and bubble handling.
module tb_dependency_check_block;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_LD   = 6'h20;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        stall;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [15:0] imm;
  logic [1:0]  mux_sel_A;
  logic [1:0]  mux_sel_B;
  logic        imm_sel;
  logic [4:0]  RW_dm;
  logic        wr_dm;

  int n_checks = 0;
  int n_fail   = 0;

  dependency_check_block dut (
    .clk       (clk),
    .reset     (reset),
    .ins       (ins),
    .ins_valid (ins_valid),
    .stall     (stall),
    .RA        (RA),
    .RB        (RB),
    .imm       (imm),
    .mux_sel_A (mux_sel_A),
    .mux_sel_B (mux_sel_B),
    .imm_sel   (imm_sel),
    .RW_dm     (RW_dm),
    .wr_dm     (wr_dm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rw,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {op, rw, ra, rb, 11'h000};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rw,
                                     input logic [4:0] ra, input logic [15:0] im);
    return {op, rw, ra, im};
  endfunction

  task automatic step(input logic [31:0] i, input logic v);
    ins       = i;
    ins_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) step(32'h0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_ra"}, 32'(RA), 32'h0);
    check({tag, "_rb"}, 32'(RB), 32'h0);
    check({tag, "_imm"}, 32'(imm), 32'h0);
    check({tag, "_sela"}, 32'(mux_sel_A), 32'h0);
    check({tag, "_selb"}, 32'(mux_sel_B), 32'h0);
    check({tag, "_immsel"}, 32'(imm_sel), 32'h0);
    check({tag, "_rwdm"}, 32'(RW_dm), 32'h0);
    check({tag, "_wrdm"}, 32'(wr_dm), 32'h0);
  endtask

  initial begin
    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    // reset mid-stream with three ALU instructions in flight
    step(rr(OP_ADD, 5'd1, 5'd3, 5'd4), 1'b1);
    step(rr(OP_ADD, 5'd2, 5'd3, 5'd4), 1'b1);
    step(rr(OP_ADD, 5'd9, 5'd2, 5'd4), 1'b1);
    check("pre_rst_wrdm", 32'(wr_dm), 32'h1);
    check("pre_rst_rwdm", 32'(RW_dm), 32'd1);
    check("pre_rst_sela", 32'(mux_sel_A), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    ins = rr(OP_ADD, 5'd10, 5'd11, 5'd12);
    ins_valid = 1'b1;
    #1;
    check("post_rst_wrdm0", 32'(wr_dm), 32'h0);
    step(rr(OP_ADD, 5'd10, 5'd11, 5'd12), 1'b1);
    check("post_rst_wrdm1", 32'(wr_dm), 32'h0);
    step(rr(OP_ADD, 5'd11, 5'd11, 5'd12), 1'b1);
    check("post_rst_wrdm2", 32'(wr_dm), 32'h0);
    step(32'h0, 1'b0);
    check("post_rst_first", 32'(wr_dm), 32'h1);
    check("post_rst_rw", 32'(RW_dm), 32'd10);
    flush();

    // forwarding distance: gap 0..3 between writer of R7 and reader
    for (int gap = 0; gap < 4; gap++) begin
      logic [1:0] exp_sel;
      exp_sel = (gap == 0) ? 2'b01 : (gap == 1) ? 2'b10 : (gap == 2) ? 2'b11 : 2'b00;
      step(rr(OP_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
      for (int g = 0; g < gap; g++) step(rr(OP_ADD, 5'd1, 5'd2, 5'd3), 1'b1);
      step(rr(OP_ADD, 5'd8, 5'd7, 5'd9), 1'b1);
      check($sformatf("gap%0d_sela", gap), 32'(mux_sel_A), 32'(exp_sel));
      check($sformatf("gap%0d_selb", gap), 32'(mux_sel_B), 32'h0);
      check($sformatf("gap%0d_stall", gap), 32'(stall), 32'h0);
      flush();
    end

    // EX beats DM
    step(rr(OP_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
    step(rr(OP_ADD, 5'd7, 5'd3, 5'd4), 1'b1);
    step(rr(OP_ADD, 5'd8, 5'd7, 5'd7), 1'b1);
    check("prio_sela", 32'(mux_sel_A), 32'h1);
    check("prio_selb", 32'(mux_sel_B), 32'h1);
    flush();

    // load-use on RB
    step(ri(OP_LD, 5'd5, 5'd1, 16'h0004), 1'b1);
    step(rr(OP_ADD, 5'd6, 5'd2, 5'd5), 1'b1);
    check("lu_stall", 32'(stall), 32'h1);
    check("lu_hold_rb", 32'(RB), 32'd5);
    step(rr(OP_ADD, 5'd6, 5'd2, 5'd5), 1'b1);
    check("lu_stall_one", 32'(stall), 32'h0);
    check("lu_selb", 32'(mux_sel_B), 32'h2);
    check("lu_sela", 32'(mux_sel_A), 32'h0);
    check("lu_wrdm", 32'(wr_dm), 32'h1);
    check("lu_rwdm", 32'(RW_dm), 32'd5);
    step(32'h0, 1'b0);
    check("lu_after_stall", 32'(stall), 32'h0);
    check("lu_bubble_wrdm", 32'(wr_dm), 32'h0);
    check("lu_bubble_rwdm", 32'(RW_dm), 32'h0);
    flush();

    // stall with ins_valid low keeps the held instruction
    step(ri(OP_LD, 5'd5, 5'd1, 16'h0000), 1'b1);
    step(rr(OP_ADD, 5'd6, 5'd5, 5'd3), 1'b1);
    check("luv_stall", 32'(stall), 32'h1);
    step(32'h0, 1'b0);
    check("luv_ra", 32'(RA), 32'd5);
    check("luv_sela", 32'(mux_sel_A), 32'h2);
    check("luv_stall_one", 32'(stall), 32'h0);
    flush();

    // ALU-immediate: B comes from imm regardless of RB field
    step(rr(OP_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
    step(ri(OP_ADDI, 5'd3, 5'd4, 16'hFFFF), 1'b1);
    check("ri_immsel", 32'(imm_sel), 32'h1);
    check("ri_selb", 32'(mux_sel_B), 32'h0);
    check("ri_imm", 32'(imm), 32'h0000FFFF);
    flush();
    step(rr(OP_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
    step(ri(OP_ADDI, 5'd3, 5'd7, 16'h3FFF), 1'b1);
    check("ri7_rb", 32'(RB), 32'd7);
    check("ri7_selb", 32'(mux_sel_B), 32'h0);
    check("ri7_sela", 32'(mux_sel_A), 32'h1);
    check("ri7_imm", 32'(imm), 32'h00003FFF);
    flush();
    step(ri(OP_LD, 5'd5, 5'd1, 16'h0000), 1'b1);
    step(ri(OP_ADDI, 5'd3, 5'd4, 16'h2800), 1'b1);
    check("ri_ld_nostall", 32'(stall), 32'h0);
    check("ri_ld_immsel", 32'(imm_sel), 32'h1);
    flush();

    // register 0 never forwards or stalls
    step(rr(OP_ADD, 5'd0, 5'd1, 5'd2), 1'b1);
    step(rr(OP_ADD, 5'd8, 5'd0, 5'd0), 1'b1);
    check("r0_sela", 32'(mux_sel_A), 32'h0);
    check("r0_selb", 32'(mux_sel_B), 32'h0);
    check("r0_stall", 32'(stall), 32'h0);
    flush();
    step(ri(OP_LD, 5'd0, 5'd1, 16'h0000), 1'b1);
    step(rr(OP_ADD, 5'd8, 5'd0, 5'd0), 1'b1);
    check("r0_ld_stall", 32'(stall), 32'h0);
    flush();

    // valid NOP neither reads nor writes
    step(rr(OP_ADD, 5'd4, 5'd1, 5'd2), 1'b1);
    step(rr(OP_NOP, 5'd31, 5'd4, 5'd4), 1'b1);
    check("nop_sela", 32'(mux_sel_A), 32'h0);
    check("nop_selb", 32'(mux_sel_B), 32'h0);
    check("nop_immsel", 32'(imm_sel), 32'h0);
    step(32'h0, 1'b0);
    check("nop_prev_wrdm", 32'(wr_dm), 32'h1);
    check("nop_prev_rwdm", 32'(RW_dm), 32'd4);
    step(32'h0, 1'b0);
    check("nop_wrdm", 32'(wr_dm), 32'h0);
    check("nop_rwdm", 32'(RW_dm), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
